// File: rtl/speccfa_log_rewrite_if.sv
// Detect-stage inputs and CF-Log / ACFA pointer outputs of the SpecCFA log rewriter.
// The rewriter takes the slave view; the driving environment takes the master view.
interface speccfa_log_rewrite_if;
  logic        cflow_hw_wen;
  logic [15:0] cflow_log_ptr;
  logic        detect_active;
  logic        detect_match;
  logic        detect_mismatch;
  logic [7:0]  active_block_id;
  logic [15:0] active_block_cflog_addr;
  logic        log_wr_en;
  logic [15:0] log_wr_addr;
  logic [15:0] log_wr_data;
  logic        ptr_load;
  logic [15:0] ptr_load_val;
  logic        busy;
  logic        collision;
  logic [15:0] comp_count;

  modport slave (
    input  cflow_hw_wen, cflow_log_ptr, detect_active, detect_match, detect_mismatch,
           active_block_id, active_block_cflog_addr,
    output log_wr_en, log_wr_addr, log_wr_data, ptr_load, ptr_load_val, busy, collision,
           comp_count
  );

  modport master (
    output cflow_hw_wen, cflow_log_ptr, detect_active, detect_match, detect_mismatch,
           active_block_id, active_block_cflog_addr,
    input  log_wr_en, log_wr_addr, log_wr_data, ptr_load, ptr_load_val, busy, collision,
           comp_count
  );
endinterface

// File: rtl/speccfa_log_rewrite.sv
// Replaces a fully matched speculative block in the CF-Log with one compressed
// {MARKER, id} / repeat-count pair, then rewinds the ACFA log pointer past it.
module speccfa_log_rewrite #(
  parameter logic [7:0] MARKER = 8'hFF
) (
  input logic                   clk,
  input logic                   reset,
  speccfa_log_rewrite_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWrId, StWrCnt, StRewind} state_e;

  state_e      state_q, state_d;
  logic [15:0] target_q, target_d;
  logic        last_valid_q, last_valid_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic [7:0]  last_id_q, last_id_d;
  logic [15:0] last_cnt_q, last_cnt_d;
  logic [15:0] comp_count_q, comp_count_d;
  logic        collision_q, collision_d;

  logic        log_wr_en_q, log_wr_en_d;
  logic [15:0] log_wr_addr_q, log_wr_addr_d;
  logic [15:0] log_wr_data_q, log_wr_data_d;
  logic        ptr_load_q, ptr_load_d;
  logic [15:0] ptr_load_val_q, ptr_load_val_d;
  logic        busy_q, busy_d;

  logic        busy_now;
  logic [15:0] next_slot;
  logic        is_repeat;

  assign busy_now  = (state_q != StIdle);
  assign next_slot = last_addr_q + 16'd2;
  assign is_repeat = last_valid_q && (last_id_q == bus.active_block_id) &&
                     (next_slot == bus.active_block_cflog_addr) && (last_cnt_q != 16'hFFFF);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    last_valid_d = last_valid_q;
    last_addr_d  = last_addr_q;
    last_id_d    = last_id_q;
    last_cnt_d   = last_cnt_q;
    comp_count_d = comp_count_q;
    collision_d  = collision_q | (busy_now & (bus.cflow_hw_wen | bus.detect_match));

    unique case (state_q)
      StIdle: begin
        if (bus.detect_match) begin
          if (is_repeat) begin
            last_cnt_d = last_cnt_q + 16'd1;
            target_d   = last_addr_q;
            state_d    = StWrCnt;
          end else begin
            target_d   = bus.active_block_cflog_addr;
            last_id_d  = bus.active_block_id;
            last_cnt_d = 16'd1;
            state_d    = StWrId;
          end
        end else if (bus.detect_mismatch || (bus.cflow_hw_wen && !bus.detect_active)) begin
          // Unmatched entries now follow the last compressed one: no more merging.
          last_valid_d = 1'b0;
        end
      end
      StWrId:  state_d = StWrCnt;
      StWrCnt: state_d = StRewind;
      StRewind: begin
        last_valid_d = 1'b1;
        last_addr_d  = target_q;
        comp_count_d = comp_count_q + 16'd1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    log_wr_en_d    = 1'b0;
    log_wr_addr_d  = 16'd0;
    log_wr_data_d  = 16'd0;
    ptr_load_d     = 1'b0;
    ptr_load_val_d = 16'd0;
    busy_d         = (state_d != StIdle);
    unique case (state_d)
      StWrId: begin
        log_wr_en_d   = 1'b1;
        log_wr_addr_d = target_d;
        log_wr_data_d = {MARKER, last_id_d};
      end
      StWrCnt: begin
        log_wr_en_d   = 1'b1;
        log_wr_addr_d = target_d + 16'd1;
        log_wr_data_d = last_cnt_d;
      end
      StRewind: begin
        ptr_load_d     = 1'b1;
        ptr_load_val_d = target_d + 16'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      target_q       <= 16'd0;
      last_valid_q   <= 1'b0;
      last_addr_q    <= 16'd0;
      last_id_q      <= 8'd0;
      last_cnt_q     <= 16'd0;
      comp_count_q   <= 16'd0;
      collision_q    <= 1'b0;
      log_wr_en_q    <= 1'b0;
      log_wr_addr_q  <= 16'd0;
      log_wr_data_q  <= 16'd0;
      ptr_load_q     <= 1'b0;
      ptr_load_val_q <= 16'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      last_valid_q   <= last_valid_d;
      last_addr_q    <= last_addr_d;
      last_id_q      <= last_id_d;
      last_cnt_q     <= last_cnt_d;
      comp_count_q   <= comp_count_d;
      collision_q    <= collision_d;
      log_wr_en_q    <= log_wr_en_d;
      log_wr_addr_q  <= log_wr_addr_d;
      log_wr_data_q  <= log_wr_data_d;
      ptr_load_q     <= ptr_load_d;
      ptr_load_val_q <= ptr_load_val_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.log_wr_en    = log_wr_en_q;
  assign bus.log_wr_addr  = log_wr_addr_q;
  assign bus.log_wr_data  = log_wr_data_q;
  assign bus.ptr_load     = ptr_load_q;
  assign bus.ptr_load_val = ptr_load_val_q;
  assign bus.busy         = busy_q;
  assign bus.collision    = collision_q;
  assign bus.comp_count   = comp_count_q;

endmodule

// File: tb/tb_speccfa_log_rewrite.sv
// Directed bench for speccfa_log_rewrite: expected log writes and pointer loads are
// queued with their due cycle when a match is driven and checked as they appear.
module tb_speccfa_log_rewrite;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   exp_comp = 0;
  logic exp_coll = 1'b0;

  typedef struct {
    logic        is_ptr;
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  speccfa_log_rewrite_if bus ();

  speccfa_log_rewrite #(.MARKER(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic take(input logic is_ptr, input logic [15:0] addr, input logic [15:0] data);
    exp_t e;
    n_assert++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL unexpected_event observed=ptr%0d addr %h data %h cycle %0d expected=none",
             is_ptr, addr, data, cyc);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("event_kind", {31'd0, is_ptr}, {31'd0, e.is_ptr});
      check("event_cycle", cyc, e.due);
      check(is_ptr ? "ptr_load_val" : "log_wr_addr", {16'd0, addr}, {16'd0, e.addr});
      if (!is_ptr) check("log_wr_data", {16'd0, data}, {16'd0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (bus.log_wr_en === 1'b1) take(1'b0, bus.log_wr_addr, bus.log_wr_data);
    if (bus.ptr_load === 1'b1) take(1'b1, bus.ptr_load_val, 16'h0000);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_log_wr_en"}, {31'd0, bus.log_wr_en}, 32'd0);
    check({tag, "_log_wr_addr"}, {16'd0, bus.log_wr_addr}, 32'd0);
    check({tag, "_log_wr_data"}, {16'd0, bus.log_wr_data}, 32'd0);
    check({tag, "_ptr_load"}, {31'd0, bus.ptr_load}, 32'd0);
    check({tag, "_ptr_load_val"}, {16'd0, bus.ptr_load_val}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_collision"}, {31'd0, bus.collision}, 32'd0);
    check({tag, "_comp_count"}, {16'd0, bus.comp_count}, 32'd0);
  endtask

  // One match; wen_at / match_at drive a one-cycle busy-time event at that offset.
  task automatic run_match(input logic [7:0] id, input logic [15:0] addr, input logic rep,
                           input logic [15:0] target, input logic [15:0] cnt,
                           input int wen_at, input int match_at);
    int t0;
    int off;
    @(negedge clk);
    bus.detect_match            = 1'b1;
    bus.active_block_id         = id;
    bus.active_block_cflog_addr = addr;
    bus.cflow_log_ptr           = addr + 16'd4;
    t0  = cyc;
    off = rep ? 0 : 1;
    if (!rep) exp_q.push_back('{1'b0, t0 + 1, target, {8'hFF, id}});
    exp_q.push_back('{1'b0, t0 + 1 + off, target + 16'd1, cnt});
    exp_q.push_back('{1'b1, t0 + 2 + off, target + 16'd2, 16'h0000});
    for (int k = 1; k <= 3 + off; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_after_match", {31'd0, bus.busy}, 32'd1);
      bus.detect_match = (k == match_at);
      bus.cflow_hw_wen = (k == wen_at);
    end
    exp_comp++;
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    check("comp_count", {16'd0, bus.comp_count}, exp_comp);
    check("collision", {31'd0, bus.collision}, {31'd0, exp_coll});
  endtask

  task automatic pulse(input logic wen, input logic active, input logic mism);
    @(negedge clk);
    bus.cflow_hw_wen    = wen;
    bus.detect_active   = active;
    bus.detect_mismatch = mism;
    @(negedge clk);
    bus.cflow_hw_wen    = 1'b0;
    bus.detect_active   = 1'b0;
    bus.detect_mismatch = 1'b0;
  endtask

  initial begin
    int t0;
    reset                       = 1'b1;
    bus.cflow_hw_wen            = 1'b0;
    bus.cflow_log_ptr           = 16'h0000;
    bus.detect_active           = 1'b0;
    bus.detect_match            = 1'b0;
    bus.detect_mismatch         = 1'b0;
    bus.active_block_id         = 8'h00;
    bus.active_block_cflog_addr = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // New entry, then an adjacent repeat of the same block.
    run_match(8'h05, 16'h0010, 1'b0, 16'h0010, 16'h0001, 0, 0);
    run_match(8'h05, 16'h0012, 1'b1, 16'h0010, 16'h0002, 0, 0);

    // Unmatched logging breaks the chain.
    pulse(1'b1, 1'b0, 1'b0);
    run_match(8'h05, 16'h0014, 1'b0, 16'h0014, 16'h0001, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    run_match(8'h05, 16'h0016, 1'b0, 16'h0016, 16'h0001, 0, 0);
    pulse(1'b0, 1'b0, 1'b1);
    run_match(8'h05, 16'h0018, 1'b0, 16'h0018, 16'h0001, 0, 0);
    // Logging during an active match keeps the chain; a different ID does not merge.
    pulse(1'b1, 1'b1, 1'b0);
    run_match(8'h05, 16'h001A, 1'b1, 16'h0018, 16'h0002, 0, 0);
    run_match(8'h06, 16'h001A, 1'b0, 16'h001A, 16'h0001, 0, 0);

    // Jump the repeat count near saturation, then step through it.
    @(negedge clk);
    force dut.last_cnt_q = 16'hFFFD;
    repeat (2) @(negedge clk);
    release dut.last_cnt_q;
    run_match(8'h06, 16'h001C, 1'b1, 16'h001A, 16'hFFFE, 0, 0);
    run_match(8'h06, 16'h001C, 1'b1, 16'h001A, 16'hFFFF, 0, 0);
    run_match(8'h06, 16'h001C, 1'b0, 16'h001C, 16'h0001, 0, 0);

    // Busy-time write in WR_CNT and match in REWIND: sticky collision, no disturbance.
    exp_coll = 1'b1;
    run_match(8'h05, 16'h0040, 1'b0, 16'h0040, 16'h0001, 2, 3);
    repeat (3) @(negedge clk);
    check("collision_sticky", {31'd0, bus.collision}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_comp = 0;
    exp_coll = 1'b0;
    check_all_zero("coll_reset");

    // Reset during WR_ID: only the first word is ever written.
    @(negedge clk);
    bus.detect_match            = 1'b1;
    bus.active_block_id         = 8'h05;
    bus.active_block_cflog_addr = 16'h0050;
    t0 = cyc;
    exp_q.push_back('{1'b0, t0 + 1, 16'h0050, 16'hFF05});
    @(negedge clk);
    bus.detect_match = 1'b0;
    check("wr_id_before_reset", {31'd0, bus.log_wr_en}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("mid_reset");
    repeat (6) @(negedge clk);
    check("mid_reset_busy", {31'd0, bus.busy}, 32'd0);

    // Chain state was reset, so an adjacent-looking match starts fresh.
    run_match(8'h05, 16'h0052, 1'b0, 16'h0052, 16'h0001, 0, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
